// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and controller state encoding (also used by the stall controller).
package mdu_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed from the
// operands latched at start and committed on the last busy cycle.
module mdu
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state_q;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;

  logic [63:0] prod_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        res_we_d;

  // Result datapath on the latched operands; signed divide works on magnitudes
  // so the most-negative / -1 case and the zero divisor stay well defined.
  always_comb begin
    prod_s   = 64'd0;
    mag_a_s  = a_q;
    mag_b_s  = b_q;
    quo_s    = 32'd0;
    rem_s    = 32'd0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_we_d = 1'b0;
    if (op_q == MD_DIV) begin
      mag_a_s = a_q[31] ? (32'd0 - a_q) : a_q;
      mag_b_s = b_q[31] ? (32'd0 - b_q) : b_q;
    end else begin
      mag_a_s = a_q;
      mag_b_s = b_q;
    end
    if (mag_b_s != 32'd0) begin
      quo_s = mag_a_s / mag_b_s;
      rem_s = mag_a_s % mag_b_s;
    end else begin
      quo_s = 32'd0;
      rem_s = 32'd0;
    end
    case (op_q)
      MD_MULT: begin
        prod_s   = $unsigned($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        hi_d     = prod_s[63:32];
        lo_d     = prod_s[31:0];
        res_we_d = 1'b1;
      end
      MD_MULTU: begin
        prod_s   = {32'd0, a_q} * {32'd0, b_q};
        hi_d     = prod_s[63:32];
        lo_d     = prod_s[31:0];
        res_we_d = 1'b1;
      end
      MD_DIV: begin
        lo_d     = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_s) : quo_s;
        hi_d     = a_q[31] ? (32'd0 - rem_s) : rem_s;
        res_we_d = (b_q != 32'd0);
      end
      MD_DIVU: begin
        lo_d     = quo_s;
        hi_d     = rem_s;
        res_we_d = (b_q != 32'd0);
      end
      default: begin
        res_we_d = 1'b0;
      end
    endcase
  end

  // Controller: accepts new work only in IDLE, counts down in RUN, commits HI/LO at count 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MD_NONE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q    <= md_op_e'(md_op);
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= ((md_op_e'(md_op) == MD_MULT) || (md_op_e'(md_op) == MD_MULTU))
                           ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            if (res_we_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, arithmetic, moves, divide-by-zero, reset abort
// and ignored overlapping starts, with hand-computed expected values.
module tb_mdu;
  import mdu_defs::*;

  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vecs;
  int errs;

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse across a single rising edge, then scramble A/B.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; md_op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
  endtask

  // Issue an op, check busy for n cycles with HI/LO held, then check the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hi_hold"}, HI, old_hi);
      chk({tag, "_lo_hold"}, LO, old_lo);
    end
    @(negedge clk);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    vecs = 0; errs = 0;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, NM, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, ND, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_nd", 3'd3, 32'd7, 32'hFFFF_FFFE, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD);
    run_op("divu",  3'd4, 32'd7, 32'd2, ND, 32'd1, 32'hFFFF_FFFD, 32'd1, 32'd3);
    run_op("div0",  3'd3, 32'd5, 32'd0, ND, 32'd1, 32'd3, 32'd1, 32'd3);

    issue(3'd5, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'd3);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    @(negedge clk);
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(3'd0, 32'h5555_5555, 32'd1);
    @(negedge clk);
    chk("none_busy", {31'd0, busy}, 32'd0);
    chk("none_hi", HI, 32'h1234_5678);

    // Reset during the third busy cycle of a divide aborts it.
    issue(3'd4, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (ND + 2) @(negedge clk);
    chk("abort_hi_late", HI, 32'd0);
    chk("abort_busy_late", {31'd0, busy}, 32'd0);

    // Overlapping start while busy must not change result or timing.
    issue(3'd2, 32'd3, 32'd5);
    @(negedge clk);
    chk("ovl_busy1", {31'd0, busy}, 32'd1);
    start = 1'b1; md_op = 3'd4; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; md_op = 3'd0;
    for (int k = 1; k < int'(NM); k++) begin
      @(negedge clk);
      chk("ovl_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("ovl_busy_done", {31'd0, busy}, 32'd0);
    chk("ovl_hi", HI, 32'd0);
    chk("ovl_lo", LO, 32'd15);
    @(negedge clk);
    chk("ovl_busy_after", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
